// File: rtl/mem_tile_streamer.sv
// mem_tile_streamer: moves tiles of rows between the memory port and a valid/ready datapath
module mem_tile_streamer #(
  parameter int ROW_BYTES = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [31:0]            base_addr,
  input  logic [15:0]            row_count,
  input  logic [31:0]            stride,
  input  logic [4:0]             control,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [ROW_BYTES*8-1:0] rd_data,
  output logic                   rd_last,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ROW_BYTES*8-1:0] wr_data,
  output logic                   interface_en,
  output logic                   interface_rdwr,
  output logic [4:0]             interface_control,
  output logic [31:0]            interface_addr,
  output logic [ROW_BYTES*8-1:0] din,
  input  logic [ROW_BYTES*8-1:0] bank_dout
);
  localparam int W = ROW_BYTES * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state;
  logic [31:0] addr, stride_q;
  logic [15:0] rows, issue_idx, xfer_idx;
  logic [4:0] ctrl;
  logic [W-1:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic inflight, stored, rd_fire, wr_fire, pop, pop_mem, push;
  // the returning row is presented straight from bank_dout when nothing is queued ahead of it
  assign stored = count != '0;
  assign rd_fire = state == RD && issue_idx < rows && int'(count) + int'(inflight) < FIFO_DEPTH;
  assign wr_fire = state == WR && wr_valid;
  assign rd_valid = stored || inflight;
  assign rd_data = stored ? fifo[head] : inflight ? bank_dout : '0;
  assign rd_last = rd_valid && xfer_idx == rows - 16'd1;
  assign pop = rd_valid && rd_ready;
  assign pop_mem = pop && stored;
  assign push = inflight && !(pop && !stored);
  assign busy = state == RD || state == WR;
  assign done = state == DONE;
  assign wr_ready = state == WR;
  assign interface_en = rd_fire || wr_fire;
  assign interface_rdwr = wr_fire;
  assign interface_control = busy ? ctrl : '0;
  assign interface_addr = busy ? addr : '0;
  assign din = wr_fire ? wr_data : '0;
  always_ff @(posedge clk)
    if (push) fifo[tail] <= bank_dout;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      stride_q <= '0;
      rows <= '0;
      ctrl <= '0;
      issue_idx <= '0;
      xfer_idx <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_fire;
      if (push) tail <= tail + AW'(1);
      if (pop_mem) head <= head + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop_mem);
      if (interface_en) begin
        issue_idx <= issue_idx + 16'd1;
        addr <= addr + stride_q;
      end
      if (pop) xfer_idx <= xfer_idx + 16'd1;
      case (state)
        IDLE: if (start) begin
          state <= row_count == 16'd0 ? DONE : (mode ? WR : RD);
          addr <= base_addr;
          stride_q <= stride;
          rows <= row_count;
          ctrl <= control;
          issue_idx <= '0;
          xfer_idx <= '0;
        end
        RD: if (pop && xfer_idx == rows - 16'd1) state <= DONE;
        WR: if (wr_fire && issue_idx == rows - 16'd1) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_tile_streamer.sv
// tb_mem_tile_streamer: table plus random tiles against a row-level model of the tile transfer
module tb_mem_tile_streamer;
  localparam int DEPTH = 2;
  logic clk = 0, rst = 1, start = 0, mode = 0;
  logic [31:0] base_addr = 0, stride = 0;
  logic [15:0] row_count = 0;
  logic [4:0] control = 0;
  logic busy, done, rd_valid, rd_last, wr_ready, interface_en, interface_rdwr;
  logic rd_ready = 0, wr_valid = 0;
  logic [127:0] rd_data, din, wr_data = 0, bank_dout = 0;
  logic [4:0] interface_control;
  logic [31:0] interface_addr;
  int errors = 0, checks = 0;

  mem_tile_streamer #(.ROW_BYTES(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .row_count(row_count), .stride(stride), .control(control), .busy(busy), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .interface_en(interface_en),
    .interface_rdwr(interface_rdwr), .interface_control(interface_control),
    .interface_addr(interface_addr), .din(din), .bank_dout(bank_dout)
  );

  always #5 clk = ~clk;

  // preloaded memory contents: each row is a fixed pattern of its own address
  function automatic logic [127:0] row_init(input logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_5A5A, a + 32'h1234_5678};
  endfunction

  logic [127:0] ram [logic [31:0]];
  always @(posedge clk)
    if (interface_en) begin
      if (interface_rdwr) ram[interface_addr] = din;
      else bank_dout <= ram.exists(interface_addr) ? ram[interface_addr] : row_init(interface_addr);
    end

  logic [127:0] shadow [logic [31:0]];
  function automatic logic [127:0] exp_row(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : row_init(a);
  endfunction

  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_last"}, rd_last, 0);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_en"}, interface_en, 0);
    chk({tag, "_rdwr"}, interface_rdwr, 0);
    chk({tag, "_ctrl"}, interface_control, 0);
    chk({tag, "_addr"}, interface_addr, 0);
    chk({tag, "_din"}, din, 0);
  endtask

  typedef struct {
    int mode;
    logic [31:0] base;
    int rows;
    logic [31:0] stride;
    logic [4:0] ctrl;
    int rmode;
    int vmode;
    int poke;
    int exp_done;
    logic [31:0] exp_last;
  } vec_t;

  task automatic run_tile(input vec_t v);
    logic [31:0] ea [$];
    logic [127:0] ed [$];
    logic [31:0] last_a = '0, a;
    int k_iss = 0, k_rd = 0, k_wr = 0, cyc = 1, last_hs = 0, idx;
    bit fin = 0, exp_en;
    for (int i = 0; i < v.rows; i++) begin
      a = v.base + 32'(i) * v.stride;
      ea.push_back(a);
      ed.push_back(v.mode != 0 ? {$urandom, $urandom, $urandom, $urandom} : exp_row(a));
    end
    @(posedge clk); #1;
    start = 1; mode = v.mode[0]; base_addr = v.base; row_count = 16'(v.rows);
    stride = v.stride; control = v.ctrl; rd_ready = 0; wr_valid = 0;
    @(posedge clk); #1;
    start = 0;
    while (!fin && cyc < 300) begin
      if (v.poke != 0) begin
        start = cyc == 2;
        if (cyc == 2) begin
          mode = ~v.mode[0]; base_addr = 32'hDEAD_0000; row_count = 16'd7;
          stride = 32'h40; control = ~v.ctrl;
        end
      end
      rd_ready = v.rmode == 0 ? 1'b1 : v.rmode == 1 ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
      wr_valid = v.vmode == 0 ? 1'b1 : v.vmode == 1 ? (cyc != 2) : 1'($urandom_range(0, 1));
      wr_data = k_wr < v.rows ? ed[k_wr] : {$urandom, $urandom, $urandom, $urandom};
      #1;
      if (done) begin
        fin = 1;
        chk("done_cycle", cyc, v.rows == 0 ? 1 : last_hs + 1);
        chk("busy_at_done", busy, 0);
        chk("en_at_done", interface_en, 0);
        if (v.exp_done >= 0) chk("done_vs_table", cyc, v.exp_done);
      end else begin
        chk("busy", busy, 1);
        exp_en = v.mode != 0 ? (wr_valid && k_wr < v.rows) : (k_iss < v.rows && k_iss - k_rd < DEPTH);
        chk("issue_en", interface_en, exp_en);
        chk("rd_valid", rd_valid, v.mode == 0 && k_rd < k_iss);
        if (interface_en) begin
          idx = v.mode != 0 ? k_wr : k_iss;
          if (idx < v.rows) begin
            chk("addr", interface_addr, ea[idx]);
            chk("rdwr", interface_rdwr, v.mode[0]);
            chk("ctrl", interface_control, v.ctrl);
            if (v.mode != 0) chk("din", din, ed[idx]);
            last_a = interface_addr;
          end
        end
        if (v.mode == 0 && rd_valid && rd_ready && k_rd < v.rows) begin
          chk("rd_data", rd_data, ed[k_rd]);
          chk("rd_last", rd_last, k_rd == v.rows - 1);
          k_rd++;
          last_hs = cyc;
        end
        if (v.mode != 0 && wr_valid && wr_ready && k_wr < v.rows) begin
          k_wr++;
          last_hs = cyc;
        end
        if (v.mode == 0 && interface_en) k_iss++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    if (v.rows > 0) chk("last_addr", last_a, v.exp_last);
    chk("rows_moved", v.mode != 0 ? k_wr : k_rd, v.rows);
    if (v.mode != 0) for (int i = 0; i < v.rows; i++) shadow[ea[i]] = ed[i];
    start = 0;
    @(posedge clk); #1;
    rd_ready = 0; wr_valid = 0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_en", interface_en, 0);
    chk("idle_ctrl", interface_control, 0);
  endtask

  vec_t tbl [9];
  vec_t r, last_w;
  bit have_w = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl = '{
      '{0, 32'h100, 4, 32'd16, 5'h11, 0, 0, 0, 6, 32'h130},
      '{0, 32'h500, 5, 32'd16, 5'h03, 1, 0, 0, -1, 32'h540},
      '{1, 32'h40, 3, 32'd32, 5'h1F, 0, 1, 0, 5, 32'h80},
      '{0, 32'h40, 3, 32'd32, 5'h05, 0, 0, 0, 5, 32'h80},
      '{0, 32'h800, 0, 32'd16, 5'h07, 0, 0, 0, 1, 32'h0},
      '{1, 32'h900, 0, 32'd16, 5'h08, 0, 0, 0, 1, 32'h0},
      '{0, 32'hFFFF_FFF0, 2, 32'd16, 5'h12, 0, 0, 0, 4, 32'h0},
      '{1, 32'hFFFF_FFF0, 2, 32'd16, 5'h13, 0, 0, 0, 3, 32'h0},
      '{0, 32'h200, 3, 32'd16, 5'h09, 0, 0, 1, 5, 32'h220}
    };
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 0;
    foreach (tbl[i]) run_tile(tbl[i]);
    // reset while the second row of a four-row read is being handed over
    @(posedge clk); #1;
    start = 1; mode = 0; base_addr = 32'h300; row_count = 16'd4; stride = 32'd16;
    control = 5'h0A; rd_ready = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    chk("mid_rd_valid", rd_valid, 1);
    chk("mid_rd_data", rd_data, exp_row(32'h310));
    rst = 1;
    @(posedge clk); #1;
    #1;
    check_zero("abort");
    rst = 0;
    @(posedge clk); #1;
    #1;
    check_zero("after_abort");
    rd_ready = 0;
    run_tile('{0, 32'h300, 4, 32'd16, 5'h0B, 0, 0, 0, 6, 32'h330});
    for (int i = 0; i < 14; i++) begin
      if (have_w && $urandom_range(0, 2) == 0) begin
        r = last_w;
        r.mode = 0;
      end else begin
        r.mode = int'($urandom_range(0, 1));
        r.base = $urandom_range(0, 3) == 0 ? 32'hFFFF_FF80 + 32'($urandom_range(0, 7)) * 16 : $urandom;
        r.rows = int'($urandom_range(0, 8));
        r.stride = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 4)) * 16;
        r.ctrl = 5'($urandom);
      end
      r.rmode = 2;
      r.vmode = 2;
      r.poke = 0;
      r.exp_done = -1;
      r.exp_last = r.base + 32'(r.rows - 1) * r.stride;
      if (r.mode != 0) begin
        last_w = r;
        have_w = 1;
      end
      run_tile(r);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
